decode: RTL
===========

Name: decode

Overview:
- Instruction decode stage of the ppcpu pipeline.
- Sits between fetch and execute: accepts instruction words from fetch through a valid/ready handshake.
- Assembles two-word instructions (opcode word + immediate word).
- Drives a registered control bundle that connects one-to-one to the execute stage control inputs, and honours execute's ready signal.

Parameters:
- none; widths come from config.v: `RW, `REGNO, `REGNO_LOG, `ALU_MODE_W.

Ports:
- i_clk  input  1  clock
- i_rst  input  1  synchronous active-high reset
- i_instr  input  `RW  instruction word from fetch
- i_valid  input  1  i_instr valid
- o_ready  output  1  decode can accept a word this cycle
- i_exec_ready  input  1  ready from execute stage
- o_imm  output  `RW  immediate to execute
- c_pc_inc  output  1  PC increment
- c_pc_ie  output  1  PC load from ALU bus
- c_r_bus_imm  output  1  ALU right operand = immediate
- c_alu_mode  output  `ALU_MODE_W  ALU mode
- c_alu_carry_en  output  1  use stored carry
- c_alu_flags_ie  output  1  flag register write enable
- c_l_reg_sel  output  `REGNO_LOG  left register select
- c_r_reg_sel  output  `REGNO_LOG  right register select
- c_rf_ie  output  `REGNO  one-hot register write enable

Behaviour:
- Reset: i_rst is synchronous and active-high, sampled on i_clk.
  - Reset state: state=S_OP, all outputs 0 (NOP bundle), o_ready=0 while i_rst=1.
  - Reset mid-instruction (in S_IMM) discards the held opcode.
- Word encoding: [15:12] opcode, [11:9] rd, [8:6] rs1, [5:3] rs2, [2:0] ignored.
- ALU mode codes are `ALU_MODE_PASSR, `ALU_MODE_ADD, `ALU_MODE_SUB from config.v.
- Opcodes:
  - 0 NOP: bundle all 0 except c_pc_inc.
  - 1 MOV rd,rs2: PASSR, r_sel=rs2, rf_ie=1<<rd.
  - 2 LDI rd,imm (2 words): PASSR, r_bus_imm=1, rf_ie=1<<rd.
  - 3 ADD rd,rs1,rs2: ADD, l_sel=rs1, r_sel=rs2, rf_ie=1<<rd, flags_ie=1.
  - 4 ADC: as ADD plus carry_en=1.
  - 5 SUB: as ADD with SUB mode.
  - 6 ADDI rd,rs1,imm (2 words): ADD, r_bus_imm=1, flags_ie=1.
  - 7 JMP imm (2 words): PASSR, r_bus_imm=1, c_pc_ie=1, c_pc_inc=0.
  - 8-15: illegal.
- c_pc_inc=1 on every issued bundle except JMP.
- Unused select fields are 0.
- Handshake:
  - o_ready = i_exec_ready & ~i_rst (combinational).
  - A word is accepted when i_valid & o_ready.
- Output bundle register:
  - Updates only when i_exec_ready=1; held unchanged when i_exec_ready=0.
  - If i_exec_ready=1 and nothing is issued, the bundle becomes NOP with c_pc_inc=0.
  - This guarantees each bundle is presented for exactly one execute-ready cycle.
- State S_OP, accepted word:
  - One-word opcode: issue its bundle next cycle, stay in S_OP.
  - Two-word opcode: latch opcode/rd/rs1, issue a pc-advance bubble (only c_pc_inc=1), go to S_IMM.
- State S_IMM, accepted word:
  - Word loaded into o_imm; issue the held instruction's bundle next cycle; go to S_OP.
  - The immediate word is never decoded as an opcode.
- No accepted word: state unchanged; no timeout in S_IMM.
- Latency: accepted word to bundle visible on outputs = 1 cycle.
- o_imm holds its last value between immediates; o_imm=0 after reset.

Optional Feature:
- Macro: DECODE_ILLEGAL_TRAP_EN.
- Defined:
  - Adds output o_illegal (1 bit), sticky.
  - Set the cycle after an illegal opcode word is accepted.
  - Cleared only by i_rst.
  - The illegal word issues a NOP bundle with c_pc_inc=1.
- Undefined:
  - No o_illegal port.
  - Illegal opcodes silently decode as NOP with c_pc_inc=1.

Test Plan:
- Reset: hold i_rst 2 cycles with i_valid=1, i_instr=0x3298 -> o_ready=0, all outputs 0; after release, first bundle appears only after a new accept.
- ADD r1,r2,r3: i_instr=0x3298 accepted -> next cycle l_sel=2, r_sel=3, rf_ie=8'h02, mode=ADD, flags_ie=1, pc_inc=1; following idle cycle all 0.
- LDI r5,0x1234: words 0x2A00 then 0x1234 on consecutive cycles -> bubble (pc_inc=1 only), then rf_ie=8'h20, r_bus_imm=1, o_imm=0x1234, mode=PASSR.
- JMP 0x0040 with i_valid gap of 3 cycles between words -> state waits in S_IMM, NOP bundles during gap, then pc_ie=1, pc_inc=0, o_imm=0x0040.
- Backpressure: i_exec_ready=0 while ADC r0,r0,r1 (0x4008) is pending -> o_ready=0, bundle held; raise i_exec_ready -> accept and carry_en=1 next cycle.
- Illegal opcode 0xF000 -> NOP bundle with pc_inc=1; with DECODE_ILLEGAL_TRAP_EN, o_illegal=1 until reset; reset during S_IMM of LDI -> next word 0x1234 decodes as opcode 1 (MOV).

Source files
------------

// File: rtl/decode.sv
// ppcpu decode stage: turns fetched words, including two-word opcode+immediate pairs, into a registered execute control bundle.
// Optional feature: define DECODE_ILLEGAL_TRAP_EN to add the sticky o_illegal output.

`ifndef RW
`define RW 16
`endif
`ifndef REGNO
`define REGNO 8
`endif
`ifndef REGNO_LOG
`define REGNO_LOG 3
`endif
`ifndef ALU_MODE_W
`define ALU_MODE_W 2
`endif
`ifndef ALU_MODE_PASSR
`define ALU_MODE_PASSR 2'd1
`endif
`ifndef ALU_MODE_ADD
`define ALU_MODE_ADD 2'd2
`endif
`ifndef ALU_MODE_SUB
`define ALU_MODE_SUB 2'd3
`endif

module decode (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [`RW-1:0]         i_instr,
    input  logic                   i_valid,
    output logic                   o_ready,
`ifdef DECODE_ILLEGAL_TRAP_EN
    output logic                   o_illegal,
`endif
    input  logic                   i_exec_ready,
    output logic [`RW-1:0]         o_imm,
    output logic                   c_pc_inc,
    output logic                   c_pc_ie,
    output logic                   c_r_bus_imm,
    output logic [`ALU_MODE_W-1:0] c_alu_mode,
    output logic                   c_alu_carry_en,
    output logic                   c_alu_flags_ie,
    output logic [`REGNO_LOG-1:0]  c_l_reg_sel,
    output logic [`REGNO_LOG-1:0]  c_r_reg_sel,
    output logic [`REGNO-1:0]      c_rf_ie
);

    typedef enum logic [0:0] {S_OP = 1'b0, S_IMM = 1'b1} state_t;

    typedef struct packed {
        logic                   pc_inc;
        logic                   pc_ie;
        logic                   r_bus_imm;
        logic [`ALU_MODE_W-1:0] alu_mode;
        logic                   carry_en;
        logic                   flags_ie;
        logic [`REGNO_LOG-1:0]  l_sel;
        logic [`REGNO_LOG-1:0]  r_sel;
        logic [`REGNO-1:0]      rf_ie;
    } ctrl_t;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_MOV  = 4'd1;
    localparam logic [3:0] OP_LDI  = 4'd2;
    localparam logic [3:0] OP_ADD  = 4'd3;
    localparam logic [3:0] OP_ADC  = 4'd4;
    localparam logic [3:0] OP_SUB  = 4'd5;
    localparam logic [3:0] OP_ADDI = 4'd6;
    localparam logic [3:0] OP_JMP  = 4'd7;

    function automatic logic is_two_word(input logic [3:0] op);
        return (op == OP_LDI) || (op == OP_ADDI) || (op == OP_JMP);
    endfunction

    function automatic logic [`REGNO-1:0] onehot(input logic [`REGNO_LOG-1:0] idx);
        return {{(`REGNO-1){1'b0}}, 1'b1} << idx;
    endfunction

    // Full bundle for an issued instruction; illegal opcodes fall through as a plain NOP.
    function automatic ctrl_t decode_op(input logic [3:0] op,
                                        input logic [`REGNO_LOG-1:0] rd,
                                        input logic [`REGNO_LOG-1:0] rs1,
                                        input logic [`REGNO_LOG-1:0] rs2);
        ctrl_t c;
        c        = '0;
        c.pc_inc = 1'b1;
        case (op)
            OP_NOP: c.pc_inc = 1'b1;
            OP_MOV: begin
                c.alu_mode = `ALU_MODE_PASSR;
                c.r_sel    = rs2;
                c.rf_ie    = onehot(rd);
            end
            OP_LDI: begin
                c.alu_mode  = `ALU_MODE_PASSR;
                c.r_bus_imm = 1'b1;
                c.rf_ie     = onehot(rd);
            end
            OP_ADD, OP_ADC, OP_SUB: begin
                c.alu_mode = (op == OP_SUB) ? `ALU_MODE_SUB : `ALU_MODE_ADD;
                c.carry_en = (op == OP_ADC);
                c.flags_ie = 1'b1;
                c.l_sel    = rs1;
                c.r_sel    = rs2;
                c.rf_ie    = onehot(rd);
            end
            OP_ADDI: begin
                c.alu_mode  = `ALU_MODE_ADD;
                c.r_bus_imm = 1'b1;
                c.flags_ie  = 1'b1;
                c.l_sel     = rs1;
                c.rf_ie     = onehot(rd);
            end
            OP_JMP: begin
                c.alu_mode  = `ALU_MODE_PASSR;
                c.r_bus_imm = 1'b1;
                c.pc_ie     = 1'b1;
                c.pc_inc    = 1'b0;
            end
            default: c.pc_inc = 1'b1;
        endcase
        return c;
    endfunction

    state_t                state_r, state_nxt_s;
    ctrl_t                 ctrl_r, ctrl_nxt_s;
    logic [`RW-1:0]        imm_r;
    logic [3:0]            held_op_r;
    logic [`REGNO_LOG-1:0] held_rd_r, held_rs1_r;
    logic                  accept_s;
    logic [3:0]            op_s;
    logic [`REGNO_LOG-1:0] rd_s, rs1_s, rs2_s;
    logic                  unused_bits_s;

    assign o_ready       = i_exec_ready & ~i_rst;
    assign accept_s      = i_valid & o_ready;
    assign op_s          = i_instr[15:12];
    assign rd_s          = i_instr[11:9];
    assign rs1_s         = i_instr[8:6];
    assign rs2_s         = i_instr[5:3];
    assign unused_bits_s = ^i_instr[2:0];

    // State register; also captures the first word of a two-word instruction.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r    <= S_OP;
            held_op_r  <= 4'd0;
            held_rd_r  <= '0;
            held_rs1_r <= '0;
        end else begin
            state_r <= state_nxt_s;
            if (accept_s && (state_r == S_OP)) begin
                held_op_r  <= op_s;
                held_rd_r  <= rd_s;
                held_rs1_r <= rs1_s;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        if (accept_s) begin
            case (state_r)
                S_OP: begin
                    if (is_two_word(op_s)) state_nxt_s = S_IMM;
                    else                   state_nxt_s = S_OP;
                end
                S_IMM:   state_nxt_s = S_OP;
                default: state_nxt_s = S_OP;
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Bundle to issue next cycle; with no accepted word it is a non-advancing NOP.
    always_comb begin
        ctrl_nxt_s = '0;
        if (accept_s) begin
            case (state_r)
                S_OP: begin
                    if (is_two_word(op_s)) ctrl_nxt_s.pc_inc = 1'b1;
                    else                   ctrl_nxt_s = decode_op(op_s, rd_s, rs1_s, rs2_s);
                end
                S_IMM:   ctrl_nxt_s = decode_op(held_op_r, held_rd_r, held_rs1_r, '0);
                default: ctrl_nxt_s = '0;
            endcase
        end else begin
            ctrl_nxt_s = '0;
        end
    end

    // Output bundle register: frozen while execute is stalled so each bundle is seen once.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ctrl_r <= '0;
            imm_r  <= '0;
        end else if (i_exec_ready) begin
            ctrl_r <= ctrl_nxt_s;
            if (accept_s && (state_r == S_IMM)) imm_r <= i_instr;
        end
    end

`ifdef DECODE_ILLEGAL_TRAP_EN
    logic illegal_r;

    // Sticky trap flag for an illegal opcode word.
    always_ff @(posedge i_clk) begin
        if (i_rst)                                          illegal_r <= 1'b0;
        else if (accept_s && (state_r == S_OP) && op_s[3]) illegal_r <= 1'b1;
    end

    assign o_illegal = illegal_r;
`endif

    assign o_imm          = imm_r;
    assign c_pc_inc       = ctrl_r.pc_inc;
    assign c_pc_ie        = ctrl_r.pc_ie;
    assign c_r_bus_imm    = ctrl_r.r_bus_imm;
    assign c_alu_mode     = ctrl_r.alu_mode;
    assign c_alu_carry_en = ctrl_r.carry_en;
    assign c_alu_flags_ie = ctrl_r.flags_ie;
    assign c_l_reg_sel    = ctrl_r.l_sel;
    assign c_r_reg_sel    = ctrl_r.r_sel;
    assign c_rf_ie        = ctrl_r.rf_ie;

endmodule
